// File: rtl/iob_csrs_demo_core.sv
// Demo CSR block on an IOb native slave: CTRL, SCRATCH, gated counter, STATUS, VERSION.
// Reads return data the cycle after acceptance; ready drops while a read response is held unconsumed.
module iob_csrs_demo_core #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] VERSION = 32'h0000_0081
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              iob_csrs_iob_valid_i,
  input  logic [ADDR_W-3:0] iob_csrs_iob_addr_i,
  input  logic [DATA_W-1:0] iob_csrs_iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_csrs_iob_wstrb_i,
  output logic              iob_csrs_iob_rvalid_o,
  output logic [DATA_W-1:0] iob_csrs_iob_rdata_o,
  output logic              iob_csrs_iob_ready_o,
  input  logic              iob_csrs_iob_rready_i
);

  localparam int AW = ADDR_W - 2;
  localparam int SW = DATA_W / 8;

  localparam logic [AW-1:0] A_CTRL    = AW'(0);
  localparam logic [AW-1:0] A_SCRATCH = AW'(1);
  localparam logic [AW-1:0] A_CNT     = AW'(2);
  localparam logic [AW-1:0] A_STATUS  = AW'(3);
  localparam logic [AW-1:0] A_VERSION = AW'(4);

  logic              cnt_en;
  logic [DATA_W-1:2] ctrl_hi;
  logic              clr_pend;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] cnt;
  logic              ovf;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] ctrl_rd;
  logic [DATA_W-1:0] status_rd;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] ctrl_wr;
  logic [DATA_W-1:0] scratch_wr;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [SW-1:0]     strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int k = 0; k < SW; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  assign iob_csrs_iob_ready_o  = ~rvalid | iob_csrs_iob_rready_i;
  assign iob_csrs_iob_rvalid_o = rvalid;
  assign iob_csrs_iob_rdata_o  = rdata;

  assign accept = iob_csrs_iob_valid_i & iob_csrs_iob_ready_o & cke_i;
  assign wr_en  = accept & (|iob_csrs_iob_wstrb_i);
  assign rd_en  = accept & ~(|iob_csrs_iob_wstrb_i);

  // The clear bit is never stored, so it always reads back as 0.
  assign ctrl_rd    = {ctrl_hi, 1'b0, cnt_en};
  assign status_rd  = {{(DATA_W-3){1'b0}}, ovf, (cnt == '0), cnt_en};
  assign ctrl_wr    = merge(ctrl_rd, iob_csrs_iob_wdata_i, iob_csrs_iob_wstrb_i);
  assign scratch_wr = merge(scratch, iob_csrs_iob_wdata_i, iob_csrs_iob_wstrb_i);

  always_comb begin
    rd_mux = '0;
    case (iob_csrs_iob_addr_i)
      A_CTRL:    rd_mux = ctrl_rd;
      A_SCRATCH: rd_mux = scratch;
      A_CNT:     rd_mux = cnt;
      A_STATUS:  rd_mux = status_rd;
      A_VERSION: rd_mux = VERSION;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_en   <= 1'b0;
      ctrl_hi  <= '0;
      clr_pend <= 1'b0;
      scratch  <= '0;
    end else if (cke_i) begin
      clr_pend <= 1'b0;
      if (wr_en && iob_csrs_iob_addr_i == A_CTRL) begin
        cnt_en   <= ctrl_wr[0];
        ctrl_hi  <= ctrl_wr[DATA_W-1:2];
        clr_pend <= iob_csrs_iob_wstrb_i[0] & iob_csrs_iob_wdata_i[1];
      end
      if (wr_en && iob_csrs_iob_addr_i == A_SCRATCH) begin
        scratch <= scratch_wr;
      end
    end
  end

  // A pending clear takes priority over the increment on the same edge.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (cke_i) begin
      if (clr_pend) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (cnt_en) begin
        cnt <= cnt + 1'b1;
        if (&cnt) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_en) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (cke_i && iob_csrs_iob_rready_i) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_csrs_demo_core.sv
// Bench for iob_csrs_demo_core: directed register-map checks plus a randomized run against a register-level model.
module tb_iob_csrs_demo_core;

  logic        clk    = 1'b0;
  logic        cke    = 1'b1;
  logic        arst_n = 1'b0;
  logic        valid  = 1'b0;
  logic [2:0]  addr   = 3'd0;
  logic [31:0] wdata  = 32'h0;
  logic [3:0]  wstrb  = 4'h0;
  logic        rready = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  iob_csrs_demo_core dut (
    .clk_i                 (clk),
    .cke_i                 (cke),
    .arst_i                (arst_n),
    .iob_csrs_iob_valid_i  (valid),
    .iob_csrs_iob_addr_i   (addr),
    .iob_csrs_iob_wdata_i  (wdata),
    .iob_csrs_iob_wstrb_i  (wstrb),
    .iob_csrs_iob_rvalid_o (rvalid),
    .iob_csrs_iob_rdata_o  (rdata),
    .iob_csrs_iob_ready_o  (ready),
    .iob_csrs_iob_rready_i (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Register-level reference: architectural state of the map plus the pending read response.
  logic [31:0] m_ctrl = 0, m_scratch = 0, m_cnt = 0, m_rdata = 0, m_rd = 0;
  logic        m_ovf = 0, m_clr = 0, m_rvalid = 0, m_acc = 0, m_clr_next = 0;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_ctrl;
      3'd1:    return m_scratch;
      3'd2:    return m_cnt;
      3'd3:    return {29'b0, m_ovf, (m_cnt == 32'h0), m_ctrl[0]};
      3'd4:    return 32'h0000_0081;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_ctrl = 0; m_scratch = 0; m_cnt = 0; m_ovf = 0; m_clr = 0;
      m_rvalid = 0; m_rdata = 0;
    end else if (cke) begin
      m_rd  = m_read(addr);
      m_acc = valid && (!m_rvalid || rready);
      if (m_clr) begin
        m_cnt = 0;
        m_ovf = 0;
      end else if (m_ctrl[0]) begin
        if (m_cnt == 32'hFFFF_FFFF) m_ovf = 1;
        m_cnt = m_cnt + 1;
      end
      m_clr_next = 0;
      if (m_acc && wstrb != 4'h0) begin
        for (int k = 0; k < 4; k++) begin
          if (wstrb[k] && addr == 3'd0) m_ctrl[8*k +: 8] = wdata[8*k +: 8];
          if (wstrb[k] && addr == 3'd1) m_scratch[8*k +: 8] = wdata[8*k +: 8];
        end
        if (addr == 3'd0) begin
          m_clr_next = wstrb[0] && wdata[1];
          m_ctrl[1]  = 1'b0;
        end
      end
      m_clr = m_clr_next;
      if (m_acc && wstrb == 4'h0) begin
        m_rvalid = 1;
        m_rdata  = m_rd;
      end else if (rready) begin
        m_rvalid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("cmp_rdata",  rdata, m_rdata);
    chk("cmp_ready",  32'(ready), 32'(!m_rvalid || rready));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_req(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready && cke;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) chk("req_timeout", 32'd0, 32'd1);
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    rready = 1'b1;
    bus_req(a, d, s);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    rready = 1'b1;
    bus_req(a, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_vld_next_cycle", 32'(rvalid), 32'd1);
    d = rdata;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    tick(3);
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ready",  32'(ready), 32'd1);
    arst_n = 1'b1;
    tick(1);

    do_read(3'd0, d); chk("rst_ctrl", d, 32'h0);
    do_read(3'd1, d); chk("rst_scratch", d, 32'h0);
    do_read(3'd2, d); chk("rst_cnt", d, 32'h0);
    do_read(3'd4, d); chk("version", d, 32'h0000_0081);

    do_write(3'd1, 32'hDEAD_BEEF, 4'hF);
    do_read(3'd1, d); chk("scratch_full", d, 32'hDEAD_BEEF);
    do_write(3'd1, 32'h0000_0055, 4'h1);
    do_read(3'd1, d); chk("scratch_byte0", d, 32'hDEAD_BE55);

    do_write(3'd0, 32'h1, 4'hF);
    tick(9);
    do_write(3'd0, 32'h0, 4'hF);
    do_read(3'd2, d); chk("cnt_10", d, 32'd10);
    do_read(3'd3, d); chk("status_run", d, 32'h0);

    do_write(3'd0, 32'h2, 4'hF);
    tick(1);
    do_read(3'd2, d); chk("cnt_cleared", d, 32'h0);
    do_read(3'd3, d); chk("status_zero", d, 32'h2);
    do_read(3'd0, d); chk("ctrl_selfclr", d, 32'h0);

    rready = 1'b0;
    bus_req(3'd1, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata",  rdata, 32'hDEAD_BE55);
      chk("hold_ready",  32'(ready), 32'd0);
    end
    tick(1);
    rready = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(ready), 32'd1);
    @(negedge clk);
    chk("release_rvalid", 32'(rvalid), 32'd0);
    tick(1);

    for (int a = 5; a < 8; a++) begin
      do_read(3'(a), d); chk("unmapped", d, 32'h0);
    end
    do_write(3'd4, 32'hFFFF_FFFF, 4'hF);
    do_read(3'd4, d); chk("version_ro", d, 32'h0000_0081);

    rready = 1'b0;
    bus_req(3'd4, 32'h0, 4'h0);
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #1 arst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata",  rdata, 32'h0);
    tick(1);
    arst_n = 1'b1;
    rready = 1'b1;
    tick(1);

    repeat (3000) begin
      cke    = ($urandom_range(0, 7) != 0);
      valid  = ($urandom_range(0, 1) == 1);
      addr   = 3'($urandom_range(0, 7));
      wdata  = $urandom;
      wstrb  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      rready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    valid = 1'b0; wstrb = 4'h0; cke = 1'b1; rready = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_csrs_demo_core.md
Name: iob_csrs_demo_core

Overview:
- Demonstration control/status register (CSR) block on an IOb native slave bus; top-level unit exercised by the CSR-generator regression.
- Holds a small register map: two read/write registers, a gated cycle counter, a status word and a constant version word.
- Simple memory-mapped peripheral used to validate bus handshake, byte strobes and read/write semantics.

Parameters:
- ADDR_W, 5, byte address width; the bus carries word address bits [ADDR_W-1:2], giving 8 word slots.
- DATA_W, 32, data width; fixed at 32.
- VERSION, 32'h0000_0081, value returned by the VERSION register.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- cke_i  in  1  clock enable; when 0, all registers hold their value.
- arst_i  in  1  asynchronous, active-low reset.
- iob_csrs_iob_valid_i  in  1  request valid.
- iob_csrs_iob_addr_i  in  ADDR_W-2  word address.
- iob_csrs_iob_wdata_i  in  32  write data.
- iob_csrs_iob_wstrb_i  in  4  byte write strobes; nonzero means write, zero means read.
- iob_csrs_iob_rvalid_o  out  1  read data valid.
- iob_csrs_iob_rdata_o  out  32  read data.
- iob_csrs_iob_ready_o  out  1  request accepted this cycle.
- iob_csrs_iob_rready_i  in  1  master accepts read data.

Behaviour:
- Reset: arst_i=0 asynchronously clears every register, rvalid_o and rdata_o to 0, with CTRL=0, SCRATCH=0 and CNT=0. A reset asserted mid-transaction drops any pending read response.
- Handshake:
  - ready_o = ~rvalid_o | rready_i, combinational.
  - A request is accepted on a rising edge with valid_i & ready_o & cke_i.
- Write (wstrb≠0):
  - Takes effect at the accepting edge.
  - Per-byte update: byte k is written only if wstrb[k]=1.
  - No rvalid is generated.
- Read (wstrb=0):
  - rvalid_o=1 and rdata_o=register value captured at the accepting edge, valid from the next cycle.
  - rvalid_o/rdata_o hold until the edge where rready_i=1; rvalid_o then drops unless a new read is accepted at the same edge (back-to-back reads, one per cycle, with rready_i held high).
- Register map (word address / byte offset):
  - 0 / 0x00 CTRL, RW.
    - bit0 CNT_EN.
    - bit1 CNT_CLR: write-1 self-clearing; reads 0; zeroes CNT on the next edge.
    - bits[31:2] RW storage.
  - 1 / 0x04 SCRATCH, RW, 32 bits, no side effects.
  - 2 / 0x08 CNT, RO, 32-bit counter.
    - Increments by 1 each enabled cycle while CTRL.bit0=1.
    - Wraps 0xFFFF_FFFF→0.
    - If clear and increment coincide, clear wins.
  - 3 / 0x0C STATUS, RO.
    - bit0 = CNT_EN.
    - bit1 = CNT==0.
    - bit2 = sticky overflow flag: set on CNT wrap, cleared by CNT_CLR.
    - Other bits 0.
  - 4 / 0x10 VERSION, RO, returns the VERSION parameter.
  - 5–7: unmapped; reads return 0.
- Writes to RO or unmapped addresses are accepted (ready) and ignored.
- A read of CNT returns the value before that edge's increment.
- When cke_i=0: no request is accepted, the counter freezes, and outputs hold.

Test Plan:
- Reset → rdata_o=0, rvalid_o=0, ready_o=1; reading CTRL, SCRATCH and CNT returns 0 and VERSION returns 0x00000081.
- Write SCRATCH=0xDEADBEEF with wstrb=0xF, then read → rvalid one cycle after acceptance with rdata 0xDEADBEEF. Then write 0x00000055 with wstrb=0x1 → reads 0xDEADBE55.
- Write CTRL=1, wait 10 cycles, write CTRL=0; read CNT → 10 (±1 per the stated acceptance-edge rule). Read STATUS → bit0=0, bit1=0.
- Write CTRL=2 → CNT reads 0, STATUS bit1=1, CTRL reads 0.
- Hold rready_i=0 after a read → rvalid_o and rdata_o stay stable and ready_o=0; raise rready_i → rvalid_o drops next edge.
- Read addresses 5–7 → 0; write to VERSION → still 0x00000081; pulse arst_i low mid-read → rvalid_o=0 immediately.
